dat_tx_ctrl: RTL

DAT_TX_CTRL -- requirements
Module: dat_tx_ctrl

---
 rtl/dat_tx_ctrl_if.sv | 18 +
 rtl/dat_tx_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dat_tx_ctrl_if.sv
// Word handshake between the block-data source and the DAT0 transmit controller.
interface dat_tx_ctrl_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/dat_tx_ctrl.sv
// SD DAT0 single-block write controller: start bit, data via external serializer, CRC16, end bit, CRC-status and busy handling.
// Optional CRC16 generation is enabled by defining DAT_TX_CRC_EN.
module dat_tx_ctrl #(
  parameter int BLOCK_WORDS = 128,
  parameter int TIMEOUT     = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  dat_tx_ctrl_if.slave word_bus,
  output logic         ser_reset,
  output logic         ser_enable,
  output logic [31:0]  ser_data,
  input  logic         ser_out,
  input  logic         ser_complete,
  output logic         dat_out,
  output logic         dat_oe,
  output logic         dat_clk_en,
  input  logic         dat_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [2:0]   status
);

  localparam int WCW = $clog2(BLOCK_WORDS + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(BLOCK_WORDS);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_LOAD      = 4'd2;
  localparam logic [3:0] S_SHIFT     = 4'd3;
`ifdef DAT_TX_CRC_EN
  localparam logic [3:0] S_CRC       = 4'd4;
`endif
  localparam logic [3:0] S_END       = 4'd5;
  localparam logic [3:0] S_WAIT_RESP = 4'd6;
  localparam logic [3:0] S_RESP      = 4'd7;
  localparam logic [3:0] S_BUSY_WAIT = 4'd8;
  localparam logic [3:0] S_FIN       = 4'd9;

  logic [3:0]     state_reg, state_next;
  logic [WCW-1:0] word_cnt_reg, word_cnt_next;
  logic [TCW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [3:0]     bit_cnt_reg, bit_cnt_next;
  logic [2:0]     status_reg, status_next;
  logic           error_reg, error_next;
  logic [31:0]    ser_data_reg, ser_data_next;
  logic           ser_reset_reg, ser_reset_next;
  logic           dat_out_reg, dat_out_next;
  logic           dat_oe_reg, dat_oe_next;
  logic           dat_clk_en_reg, dat_clk_en_next;
  logic [31:0]    word_swapped;
`ifdef DAT_TX_CRC_EN
  logic [15:0]    crc_reg, crc_next;
  logic           crc_fb;
  assign crc_fb = ser_out ^ crc_reg[15];
`endif

  // Byte 0 lands in the top byte so the MSB-first serializer emits it first.
  for (genvar gi = 0; gi < 4; gi++) begin : g_swap
    assign word_swapped[8*gi +: 8] = word_bus.word_in[8*(3-gi) +: 8];
  end

  assign word_bus.word_ready = (state_reg == S_LOAD);
  assign ser_reset  = ser_reset_reg;
  assign ser_enable = (state_reg == S_SHIFT) && !ser_reset_reg && !ser_complete;
  assign ser_data   = ser_data_reg;
  assign dat_out    = dat_out_reg;
  assign dat_oe     = dat_oe_reg;
  assign dat_clk_en = dat_clk_en_reg;
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_FIN);
  assign error      = error_reg;
  assign status     = status_reg;

  always_comb begin
    state_next      = state_reg;
    word_cnt_next   = word_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    status_next     = status_reg;
    error_next      = error_reg;
    ser_data_next   = ser_data_reg;
    ser_reset_next  = 1'b0;
    dat_out_next    = dat_out_reg;
    dat_oe_next     = dat_oe_reg;
    dat_clk_en_next = 1'b0;
`ifdef DAT_TX_CRC_EN
    crc_next        = crc_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        dat_oe_next  = 1'b0;
        dat_out_next = 1'b1;
        if (start) begin
          state_next    = S_START;
          error_next    = 1'b0;
          status_next   = 3'b000;
          word_cnt_next = '0;
`ifdef DAT_TX_CRC_EN
          crc_next      = 16'h0000;
`endif
        end
      end
      S_START: begin
        dat_oe_next     = 1'b1;
        dat_out_next    = 1'b0;
        dat_clk_en_next = 1'b1;
        state_next      = S_LOAD;
      end
      S_LOAD: begin
        if (word_bus.word_valid) begin
          ser_data_next  = word_swapped;
          ser_reset_next = 1'b1;
          word_cnt_next  = word_cnt_reg + WCW'(1);
          state_next     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ser_enable) begin
          dat_out_next    = ser_out;
          dat_clk_en_next = 1'b1;
`ifdef DAT_TX_CRC_EN
          crc_next = {crc_reg[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
        end else if (ser_complete && !ser_reset_reg) begin
          // The complete flag is stale during the load cycle, hence the ser_reset gate.
          if (word_cnt_reg == LAST_WORD) begin
`ifdef DAT_TX_CRC_EN
            state_next   = S_CRC;
            bit_cnt_next = 4'd0;
`else
            state_next   = S_END;
`endif
          end else begin
            state_next = S_LOAD;
          end
        end
      end
`ifdef DAT_TX_CRC_EN
      S_CRC: begin
        dat_out_next    = crc_reg[15];
        dat_clk_en_next = 1'b1;
        crc_next        = {crc_reg[14:0], 1'b0};
        bit_cnt_next    = bit_cnt_reg + 4'd1;
        if (bit_cnt_reg == 4'd15) state_next = S_END;
      end
`endif
      S_END: begin
        dat_out_next    = 1'b1;
        dat_oe_next     = 1'b1;
        dat_clk_en_next = 1'b1;
        state_next      = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        dat_oe_next     = 1'b0;
        dat_out_next    = 1'b1;
        dat_clk_en_next = 1'b1;
        if (!dat_in) begin
          state_next   = S_RESP;
          bit_cnt_next = 4'd0;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          error_next = 1'b1;
          state_next = S_FIN;
        end
      end
      S_RESP: begin
        dat_clk_en_next = 1'b1;
        if (bit_cnt_reg < 4'd3) begin
          status_next  = {status_reg[1:0], dat_in};
          bit_cnt_next = bit_cnt_reg + 4'd1;
        end else if (status_reg == 3'b010 && dat_in) begin
          state_next = S_BUSY_WAIT;
        end else begin
          error_next = 1'b1;
          state_next = S_FIN;
        end
      end
      S_BUSY_WAIT: begin
        dat_clk_en_next = 1'b1;
        if (dat_in) begin
          state_next = S_FIN;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          error_next = 1'b1;
          state_next = S_FIN;
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    tmo_cnt_next = (state_next != state_reg) ? '0 : tmo_cnt_reg + TCW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      word_cnt_reg   <= '0;
      tmo_cnt_reg    <= '0;
      bit_cnt_reg    <= 4'd0;
      status_reg     <= 3'b000;
      error_reg      <= 1'b0;
      ser_data_reg   <= 32'h0;
      ser_reset_reg  <= 1'b1;
      dat_out_reg    <= 1'b1;
      dat_oe_reg     <= 1'b0;
      dat_clk_en_reg <= 1'b0;
`ifdef DAT_TX_CRC_EN
      crc_reg        <= 16'h0000;
`endif
    end else begin
      state_reg      <= state_next;
      word_cnt_reg   <= word_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      status_reg     <= status_next;
      error_reg      <= error_next;
      ser_data_reg   <= ser_data_next;
      ser_reset_reg  <= ser_reset_next;
      dat_out_reg    <= dat_out_next;
      dat_oe_reg     <= dat_oe_next;
      dat_clk_en_reg <= dat_clk_en_next;
`ifdef DAT_TX_CRC_EN
      crc_reg        <= crc_next;
`endif
    end
  end

endmodule
